// File: rtl/conv_pkg.sv
// Shared types and default sizing for the 1-D convolution engine.
package conv_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int unsigned F_MEM_SIZE_DEF       = 4;
  localparam int unsigned X_MEM_SIZE_DEF       = 8;
  localparam int unsigned F_MEM_ADDR_WIDTH_DEF = $clog2(F_MEM_SIZE_DEF);
  localparam int unsigned X_MEM_ADDR_WIDTH_DEF = $clog2(X_MEM_SIZE_DEF);

endpackage

// File: rtl/wrap_addr_counter.sv
// Modulo-MAX address counter with clear/load/increment (priority in that order)
// and a one-cycle wrap pulse when an increment leaves MAX-1.
module wrap_addr_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             incr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == LAST);
  assign wrap_o  = incr_i & at_last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (incr_i) begin
      count_d = at_last ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/conv_input_loader.sv
// Write-side controller of the X/F memories: fills both through stream handshakes,
// then hands the address counters to the output controller until conv_done.
module conv_input_loader
  import conv_pkg::*;
#(
  parameter int unsigned F_MEM_SIZE       = F_MEM_SIZE_DEF,
  parameter int unsigned X_MEM_SIZE       = X_MEM_SIZE_DEF,
  parameter int unsigned X_MEM_ADDR_WIDTH = X_MEM_ADDR_WIDTH_DEF,
  parameter int unsigned F_MEM_ADDR_WIDTH = F_MEM_ADDR_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  input  logic                        conv_done,
  input  logic                        load_xaddr,
  input  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
  input  logic                        en_xaddr_incr,
  input  logic                        en_faddr_incr,
  output logic                        wr_en_x,
  output logic                        wr_en_f,
  output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
  output logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr,
  output logic                        conv_start
);

  localparam logic [X_MEM_ADDR_WIDTH:0] X_LAST = (X_MEM_ADDR_WIDTH + 1)'(X_MEM_SIZE - 1);

  state_e state_q, state_d;
  logic   x_full_q, x_full_d;
  logic   f_full_q, f_full_d;
  logic   conv_start_q;
  logic   in_load, in_conv;
  logic   ctr_clr, x_load, x_incr, f_incr;
  logic   x_wrap, f_wrap;

  assign in_load = (state_q == LOAD);
  assign in_conv = (state_q == CONV);

  // Handshake: ready only while loading and the memory is not yet full.
  assign s_ready_x = in_load & ~x_full_q;
  assign s_ready_f = in_load & ~f_full_q;
  assign wr_en_x   = s_valid_x & s_ready_x;
  assign wr_en_f   = s_valid_f & s_ready_f;

  // Counter control: writes advance in LOAD, the output controller steers in CONV.
  assign ctr_clr = in_conv & conv_done;
  assign x_load  = in_conv & load_xaddr;
  assign x_incr  = in_load ? wr_en_x : en_xaddr_incr;
  assign f_incr  = in_load ? wr_en_f : en_faddr_incr;

  wrap_addr_counter #(
    .MAX   (X_MEM_SIZE),
    .WIDTH (X_MEM_ADDR_WIDTH)
  ) u_xaddr (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (ctr_clr),
    .load_i     (x_load),
    .load_val_i (load_xaddr_val),
    .incr_i     (x_incr),
    .count_o    (xmem_addr),
    .wrap_o     (x_wrap)
  );

  wrap_addr_counter #(
    .MAX   (F_MEM_SIZE),
    .WIDTH (F_MEM_ADDR_WIDTH)
  ) u_faddr (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (ctr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .incr_i     (f_incr),
    .count_o    (fmem_addr),
    .wrap_o     (f_wrap)
  );

  // Full flags latch on the wrapping write; CONV entered once both are set.
  always_comb begin
    state_d  = state_q;
    x_full_d = x_full_q;
    f_full_d = f_full_q;
    unique case (state_q)
      LOAD: begin
        x_full_d = x_full_q | x_wrap;
        f_full_d = f_full_q | f_wrap;
        if (x_full_d && f_full_d) state_d = CONV;
      end
      CONV: begin
        if (conv_done) begin
          state_d  = LOAD;
          x_full_d = 1'b0;
          f_full_d = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      x_full_q     <= 1'b0;
      f_full_q     <= 1'b0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_full_q     <= x_full_d;
      f_full_q     <= f_full_d;
      conv_start_q <= (state_d == CONV);
    end
  end

  assign conv_start = conv_start_q;

  a_load_xaddr_in_range : assert property (
    @(posedge clk) disable iff (reset)
    (in_conv && load_xaddr) |-> ({1'b0, load_xaddr_val} <= X_LAST)
  );

endmodule

// File: tb/tb_conv_input_loader.sv
// Randomized bench for conv_input_loader against a count-based reference model.
module tb_conv_input_loader;

  localparam int unsigned XS = 8;
  localparam int unsigned FS = 4;
  localparam int unsigned NCYC = 3000;

  logic       clk;
  logic       reset;
  logic       s_valid_x, s_ready_x, s_valid_f, s_ready_f;
  logic       conv_done, load_xaddr, en_xaddr_incr, en_faddr_incr;
  logic [2:0] load_xaddr_val;
  logic       wr_en_x, wr_en_f, conv_start;
  logic [2:0] xmem_addr;
  logic [1:0] fmem_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: how many samples/coefficients are stored, and read pointers in CONV.
  bit          m_conv;
  int unsigned m_xw, m_fw, m_xa, m_fa;

  conv_input_loader dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid_x      (s_valid_x),
    .s_ready_x      (s_ready_x),
    .s_valid_f      (s_valid_f),
    .s_ready_f      (s_ready_f),
    .conv_done      (conv_done),
    .load_xaddr     (load_xaddr),
    .load_xaddr_val (load_xaddr_val),
    .en_xaddr_incr  (en_xaddr_incr),
    .en_faddr_incr  (en_faddr_incr),
    .wr_en_x        (wr_en_x),
    .wr_en_f        (wr_en_f),
    .xmem_addr      (xmem_addr),
    .fmem_addr      (fmem_addr),
    .conv_start     (conv_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_conv = 1'b0;
    m_xw = 0; m_fw = 0; m_xa = 0; m_fa = 0;
  endtask

  task automatic check_outputs();
    bit rdy_x, rdy_f;
    rdy_x = !m_conv && (m_xw < XS);
    rdy_f = !m_conv && (m_fw < FS);
    check("s_ready_x", s_ready_x, rdy_x);
    check("s_ready_f", s_ready_f, rdy_f);
    check("wr_en_x", wr_en_x, s_valid_x && rdy_x);
    check("wr_en_f", wr_en_f, s_valid_f && rdy_f);
    check("conv_start", conv_start, m_conv);
    check("xmem_addr", xmem_addr, m_conv ? m_xa : (m_xw % XS));
    check("fmem_addr", fmem_addr, m_conv ? m_fa : (m_fw % FS));
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!m_conv) begin
      if (s_valid_x && m_xw < XS) m_xw++;
      if (s_valid_f && m_fw < FS) m_fw++;
      if (m_xw == XS && m_fw == FS) begin
        m_conv = 1'b1;
        m_xa = 0; m_fa = 0;
      end
    end else if (conv_done) begin
      model_reset();
    end else begin
      if (load_xaddr)         m_xa = load_xaddr_val;
      else if (en_xaddr_incr) m_xa = (m_xa + 1) % XS;
      if (en_faddr_incr)      m_fa = (m_fa + 1) % FS;
    end
  endtask

  initial begin
    reset = 1'b1;
    s_valid_x = 1'b0; s_valid_f = 1'b0;
    conv_done = 1'b0; load_xaddr = 1'b0; load_xaddr_val = '0;
    en_xaddr_incr = 1'b0; en_faddr_incr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 40) begin
        // Opening stretch: continuous valids, then a clean CONV window.
        reset         = 1'b0;
        s_valid_x     = 1'b1;
        s_valid_f     = 1'b1;
        conv_done     = (cyc == 30);
        load_xaddr    = (cyc == 20);
        load_xaddr_val = 3'd1;
        en_xaddr_incr = (cyc >= 12);
        en_faddr_incr = (cyc >= 12);
      end else begin
        reset          = ($urandom_range(0, 299) == 0);
        s_valid_x      = ($urandom_range(0, 9) < 6);
        s_valid_f      = ($urandom_range(0, 9) < 5);
        conv_done      = ($urandom_range(0, 15) == 0);
        load_xaddr     = ($urandom_range(0, 3) == 0);
        load_xaddr_val = 3'($urandom_range(0, XS - 1));
        en_xaddr_incr  = 1'($urandom_range(0, 1));
        en_faddr_incr  = 1'($urandom_range(0, 1));
      end
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
